// File: rtl/sipo_frame_loader_pkg.sv
// Shared definitions for the serial frame loader and the PIPO shift stage it feeds.
// Holds the loader FSM encoding and the opcode values the shifter decodes.
package sipo_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPCODE = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_LOAD   = 3'd4
  } state_t;

  localparam logic [1:0] OP_SHL = 2'd0;
  localparam logic [1:0] OP_SHR = 2'd1;
  localparam logic [1:0] OP_ASL = 2'd2;
  localparam logic [1:0] OP_ASR = 2'd3;

endpackage

// File: rtl/sipo_frame_loader_parity_acc.sv
// Running XOR over the valid bits of a frame. clear_i restarts the sum with the
// current bit (the frame_start bit is op[1] and belongs to the frame).
module frame_parity_acc (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  input  logic bit_i,
  output logic parity_o
);

  logic acc_q;
  logic acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = bit_i;
    end else if (en_i) begin
      acc_d = acc_q ^ bit_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign parity_o = acc_q;

endmodule

// File: rtl/sipo_frame_loader.sv
// Serial-to-parallel frame loader: assembles op + data (+ even parity) from a
// valid-qualified bit stream and drives the PIPO shifter with a multi-cycle load.
//
// Handshake: serial_valid is a one-way qualifier (no ready); a bit is consumed on
// every posedge where serial_valid is high, frame_start only counts alongside it.
module sipo_frame_loader
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int LOAD_CYCLES = 2,
  parameter int PARITY_EN   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       shift_en,
  output logic             load,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err,
  output state_t           dbg_state_o
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [LCW-1:0]   lc_q;
  logic [WIDTH-1:0] shreg_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_out_q;
  logic [1:0]       shift_en_q;
  logic             load_q;
  logic             busy_q;
  logic             parity_err_q;
  logic             frame_err_q;

  logic             start_accept;
  logic             parity_acc;
  logic [WIDTH-1:0] shift_word;

  // A frame_start seen in LOAD is dropped, so it must not restart the parity sum.
  assign start_accept = serial_valid && frame_start && (state_q != ST_LOAD);
  assign shift_word   = {shreg_q[WIDTH-2:0], serial_in};

  frame_parity_acc u_parity (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (start_accept),
    .en_i     (serial_valid),
    .bit_i    (serial_in),
    .parity_o (parity_acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lc_q         <= '0;
      shreg_q      <= '0;
      op_q         <= '0;
      data_out_q   <= '0;
      shift_en_q   <= '0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (serial_valid && frame_start) begin
            op_q[1] <= serial_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_OPCODE;
          end
        end
        ST_OPCODE, ST_DATA, ST_PARITY: begin
          if (serial_valid) begin
            if (frame_start) begin
              frame_err_q <= 1'b1;
              op_q[1]     <= serial_in;
              cnt_q       <= '0;
              state_q     <= ST_OPCODE;
            end else if (state_q == ST_OPCODE) begin
              op_q[0] <= serial_in;
              state_q <= ST_DATA;
            end else if (state_q == ST_DATA) begin
              shreg_q <= shift_word;
              cnt_q   <= cnt_q + 1'b1;
              if (cnt_q == CW'(WIDTH - 1)) begin
                if (PARITY_EN != 0) begin
                  state_q <= ST_PARITY;
                end else begin
                  data_out_q <= shift_word;
                  shift_en_q <= op_q;
                  load_q     <= 1'b1;
                  lc_q       <= '0;
                  state_q    <= ST_LOAD;
                end
              end
            end else if (parity_acc ^ serial_in) begin
              parity_err_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= ST_IDLE;
            end else begin
              data_out_q <= shreg_q;
              shift_en_q <= op_q;
              load_q     <= 1'b1;
              lc_q       <= '0;
              state_q    <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (serial_valid && frame_start) begin
            frame_err_q <= 1'b1;
          end
          if (lc_q == LCW'(LOAD_CYCLES - 1)) begin
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            lc_q <= lc_q + 1'b1;
          end
        end
        default: begin
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign shift_en    = shift_en_q;
  assign load        = load_q;
  assign busy        = busy_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sipo_frame_loader.sv
// Bench for sipo_frame_loader: scenario tasks drive framed bit streams, a
// negedge monitor pops expected {op,data} commits from a queue on each load rise.
module tb_sipo_frame_loader;
  import sipo_frame_pkg::*;

  localparam int W  = 16;
  localparam int LC = 2;
  localparam int PE = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         serial_in;
  logic         serial_valid;
  logic         frame_start;
  logic [W-1:0] data_out;
  logic [1:0]   shift_en;
  logic         load;
  logic         busy;
  logic         parity_err;
  logic         frame_err;
  state_t       dbg_state;

  sipo_frame_loader #(.WIDTH(W), .LOAD_CYCLES(LC), .PARITY_EN(PE)) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .data_out     (data_out),
    .shift_en     (shift_en),
    .load         (load),
    .busy         (busy),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard
  logic [W+1:0] exp_q[$];
  int           perr_cnt = 0;
  int           ferr_cnt = 0;
  int           commit_cnt = 0;
  int           load_len = 0;
  int           last_load_len = 0;
  logic         load_prev = 1'b0;
  logic [W+1:0] held = '0;
  logic [W+1:0] exp_word;

  always @(negedge clk) begin
    if (parity_err) perr_cnt++;
    if (frame_err) ferr_cnt++;
    if (load && !load_prev) begin
      commit_cnt++;
      load_len = 1;
      held = {shift_en, data_out};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL commit_unexpected: got %b/%h, required no commit", shift_en, data_out);
      end else begin
        exp_word = exp_q.pop_front();
        if ({shift_en, data_out} !== exp_word) begin
          n_err++;
          $display("FAIL commit_word: got %b/%h, required %b/%h",
                   shift_en, data_out, exp_word[W+1:W], exp_word[W-1:0]);
        end
      end
    end else if (load) begin
      load_len++;
      n_vec++;
      if ({shift_en, data_out} !== held) begin
        n_err++;
        $display("FAIL hold_under_load: got %h, required %h", {shift_en, data_out}, held);
      end
    end else if (load_prev) begin
      last_load_len = load_len;
    end
    load_prev = load;
  end

  // drivers
  task automatic idle(input int n);
    serial_valid = 1'b0;
    frame_start  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input logic st);
    serial_valid = 1'b1;
    serial_in    = b;
    frame_start  = st;
    @(posedge clk);
    #1;
    serial_valid = 1'b0;
    frame_start  = 1'b0;
  endtask

  // gap < 0 picks a random 0..2 cycle gap after each bit
  task automatic send_frame(input logic [1:0] op, input logic [W-1:0] data,
                            input logic good, input int gap);
    logic [W+2:0] f;
    logic         par;
    int           g;
    par = ^{op, data};
    f   = {op, data, good ? par : ~par};
    if (good) exp_q.push_back({op, data});
    for (int i = W + 2; i >= 0; i--) begin
      drive_bit(f[i], i == W + 2);
      if (i == 1) begin
        n_vec++;
        if (busy !== 1'b1 || load !== 1'b0) begin
          n_err++;
          $display("FAIL busy_mid_frame: busy=%b load=%b, required busy=1 load=0", busy, load);
        end
      end
      if (i > 0) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        idle(g);
      end
    end
    n_vec++;
    if (load !== good) begin
      n_err++;
      $display("FAIL load_latency: load=%b after final bit, required %b", load, good);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, budget);
    end
    idle(1);
  endtask

  task automatic check_counts(input string name, input int p_exp, input int f_exp,
                              input int c_exp);
    n_vec++;
    if (perr_cnt !== p_exp || ferr_cnt !== f_exp || commit_cnt !== c_exp) begin
      n_err++;
      $display("FAIL %s_counts: perr=%0d ferr=%0d commits=%0d, required %0d %0d %0d",
               name, perr_cnt, ferr_cnt, commit_cnt, p_exp, f_exp, c_exp);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    n_vec++;
    if (data_out !== '0) begin n_err++; $display("FAIL reset_data_out: got %h, required 0", data_out); end
    n_vec++;
    if (shift_en !== 2'b00) begin n_err++; $display("FAIL reset_shift_en: got %b, required 00", shift_en); end
    n_vec++;
    if (load !== 1'b0) begin n_err++; $display("FAIL reset_load: got %b, required 0", load); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_vec++;
    if (parity_err !== 1'b0 || frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_errs: got perr=%b ferr=%b, required 0 0", parity_err, frame_err);
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required IDLE", dbg_state); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    int p0, f0, c0;
    p0 = perr_cnt; f0 = ferr_cnt; c0 = commit_cnt;
    send_frame(2'b01, 16'hA5C3, 1'b1, 0);
    wait_idle(20);
    check_counts("basic", p0, f0, c0 + 1);
    n_vec++;
    if (last_load_len !== LC) begin
      n_err++;
      $display("FAIL basic_load_len: got %0d, required %0d", last_load_len, LC);
    end
    n_vec++;
    if (data_out !== 16'hA5C3 || shift_en !== 2'b01) begin
      n_err++;
      $display("FAIL basic_hold: got %b/%h, required 01/a5c3", shift_en, data_out);
    end
  endtask

  task automatic test_parity_err();
    int p0, f0, c0;
    p0 = perr_cnt; f0 = ferr_cnt; c0 = commit_cnt;
    send_frame(2'b01, 16'hA5C3, 1'b0, 0);
    n_vec++;
    if (parity_err !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL parity_pulse: perr=%b busy=%b, required 1 0", parity_err, busy);
    end
    idle(1);
    n_vec++;
    if (parity_err !== 1'b0) begin n_err++; $display("FAIL parity_width: got %b, required 0", parity_err); end
    idle(2);
    check_counts("parity", p0 + 1, f0, c0);
    n_vec++;
    if (data_out !== 16'hA5C3 || shift_en !== 2'b01 || load !== 1'b0) begin
      n_err++;
      $display("FAIL parity_keep: got %b/%h load=%b, required 01/a5c3 load=0", shift_en, data_out, load);
    end
  endtask

  task automatic test_frame_restart();
    int p0, f0, c0;
    p0 = perr_cnt; f0 = ferr_cnt; c0 = commit_cnt;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
    send_frame(2'b11, 16'h8001, 1'b1, 0);
    wait_idle(20);
    check_counts("restart", p0, f0 + 1, c0 + 1);
    n_vec++;
    if (data_out !== 16'h8001 || shift_en !== 2'b11) begin
      n_err++;
      $display("FAIL restart_word: got %b/%h, required 11/8001", shift_en, data_out);
    end
  endtask

  task automatic test_gapped();
    int p0, f0, c0;
    p0 = perr_cnt; f0 = ferr_cnt; c0 = commit_cnt;
    send_frame(2'b10, 16'hFFFF, 1'b1, 1);
    wait_idle(20);
    check_counts("gapped", p0, f0, c0 + 1);
    n_vec++;
    if (last_load_len !== LC) begin
      n_err++;
      $display("FAIL gapped_load_len: got %0d, required %0d", last_load_len, LC);
    end
  endtask

  task automatic test_reset_mid();
    int p0, f0, c0;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (data_out !== '0 || shift_en !== 2'b00 || load !== 1'b0 || busy !== 1'b0 ||
        dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_mid: got %b/%h load=%b busy=%b state=%0d, required all zero, IDLE",
               shift_en, data_out, load, busy, dbg_state);
    end
    reset = 1'b0;
    idle(1);
    p0 = perr_cnt; f0 = ferr_cnt; c0 = commit_cnt;
    send_frame(2'b00, 16'h0001, 1'b1, 0);
    wait_idle(20);
    check_counts("reset_mid", p0, f0, c0 + 1);
  endtask

  task automatic test_load_drop();
    int p0, f0, c0;
    p0 = perr_cnt; f0 = ferr_cnt; c0 = commit_cnt;
    send_frame(2'($urandom_range(0, 3)), W'($urandom()), 1'b1, 0);
    drive_bit(1'b1, 1'b1);
    wait_idle(20);
    check_counts("load_drop", p0, f0 + 1, c0 + 1);
    n_vec++;
    if (last_load_len !== LC) begin
      n_err++;
      $display("FAIL load_drop_len: got %0d, required %0d", last_load_len, LC);
    end
    send_frame(2'b01, 16'h1234, 1'b1, 0);
    wait_idle(20);
  endtask

  task automatic test_back_to_back();
    int p0, f0, c0;
    p0 = perr_cnt; f0 = ferr_cnt; c0 = commit_cnt;
    send_frame(2'b11, 16'h0F0F, 1'b1, 0);
    for (int i = 0; i < LC; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
    n_vec++;
    if (busy !== 1'b0 || load !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_exit: busy=%b load=%b, required 0 0", busy, load);
    end
    send_frame(2'b10, 16'hF0F0, 1'b1, 0);
    wait_idle(20);
    check_counts("b2b", p0, f0, c0 + 2);
  endtask

  task automatic test_random();
    int p_exp, f0, c_exp;
    logic good;
    p_exp = perr_cnt; f0 = ferr_cnt; c_exp = commit_cnt;
    for (int n = 0; n < 6; n++) begin
      good = ($urandom_range(0, 3) != 0);
      send_frame(2'($urandom_range(0, 3)), W'($urandom()), good, -1);
      wait_idle(20);
      if (good) c_exp++; else p_exp++;
    end
    check_counts("random", p_exp, f0, c_exp);
  endtask

  initial begin
    reset        = 1'b1;
    serial_in    = 1'b0;
    serial_valid = 1'b0;
    frame_start  = 1'b0;
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_restart();
    test_gapped();
    test_reset_mid();
    test_load_drop();
    test_back_to_back();
    test_random();
    idle(3);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expected: %0d commits missing, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
